// File: rtl/dpm_pkg.sv
// Shared constants and Hamming helpers for the dual-port ECC memory.
// Helpers work on MAX-wide vectors; callers cast to their own widths.
package dpm_pkg;

    localparam int MAX_W          = 64;
    localparam int MAX_CW         = 72;
    localparam int SYN_W          = 7;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_BANK   = 4;
    localparam int BANK_BITS      = $clog2(DEF_NUM_BANK);
    localparam int ROW_BITS       = DEF_ADDR_WIDTH - BANK_BITS;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_parity_bits(input int width);
        int p;
        p = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << p) < width + p + 1) p = p + 1;
        end
        return p;
    endfunction

    // Positions are 1-based; powers of two carry even parity, the rest carry data LSB first.
    function automatic logic [MAX_CW-1:0] hamming_encode(input logic [MAX_W-1:0] din,
                                                         input int width, input int cw);
        logic [MAX_CW-1:0] code;
        logic              par;
        int                d;
        code = '0;
        d    = 0;
        for (int pos = 1; pos <= MAX_CW; pos++) begin
            if (pos <= cw && (pos & (pos - 1)) != 0 && d < width) begin
                code[pos-1] = din[d];
                d = d + 1;
            end
        end
        for (int p = 0; p < SYN_W; p++) begin
            par = 1'b0;
            for (int pos = 1; pos <= MAX_CW; pos++) begin
                if (pos <= cw && ((pos >> p) & 1) == 1) par = par ^ code[pos-1];
            end
            if ((1 << p) <= cw) code[(1 << p) - 1] = par;
        end
        return code;
    endfunction

    function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [MAX_CW-1:0] code,
                                                          input int cw);
        logic [SYN_W-1:0] syn;
        syn = '0;
        for (int p = 0; p < SYN_W; p++) begin
            for (int pos = 1; pos <= MAX_CW; pos++) begin
                if (pos <= cw && ((pos >> p) & 1) == 1) syn[p] = syn[p] ^ code[pos-1];
            end
        end
        return syn;
    endfunction

    function automatic logic [MAX_W-1:0] hamming_data(input logic [MAX_CW-1:0] code,
                                                      input int cw);
        logic [MAX_W-1:0] data;
        int               d;
        data = '0;
        d    = 0;
        for (int pos = 1; pos <= MAX_CW; pos++) begin
            if (pos <= cw && (pos & (pos - 1)) != 0 && d < MAX_W) begin
                data[d] = code[pos-1];
                d = d + 1;
            end
        end
        return data;
    endfunction

endpackage

// File: rtl/dual_port_vif.sv
// Request/response bundle for both memory ports.
// DPM_ECC_DEBUG_EN adds the bit-flip injection inputs and correction flags.
interface dual_port_vif #(
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 8
);
    logic                  i_en_a;
    logic                  i_we_a;
    logic [ADDR_WIDTH-1:0] i_addr_a;
    logic [WIDTH-1:0]      i_din_a;
    logic [WIDTH-1:0]      o_dout_a;
    logic                  i_en_b;
    logic                  i_we_b;
    logic [ADDR_WIDTH-1:0] i_addr_b;
    logic [WIDTH-1:0]      i_din_b;
    logic [WIDTH-1:0]      o_dout_b;
`ifdef DPM_ECC_DEBUG_EN
    logic                  i_flip_a;
    logic                  i_flip_b;
    logic                  o_corr_a;
    logic                  o_corr_b;

    modport master (output i_en_a, i_we_a, i_addr_a, i_din_a, i_flip_a,
                           i_en_b, i_we_b, i_addr_b, i_din_b, i_flip_b,
                    input  o_dout_a, o_corr_a, o_dout_b, o_corr_b);
    modport slave  (input  i_en_a, i_we_a, i_addr_a, i_din_a, i_flip_a,
                           i_en_b, i_we_b, i_addr_b, i_din_b, i_flip_b,
                    output o_dout_a, o_corr_a, o_dout_b, o_corr_b);
`else
    modport master (output i_en_a, i_we_a, i_addr_a, i_din_a,
                           i_en_b, i_we_b, i_addr_b, i_din_b,
                    input  o_dout_a, o_dout_b);
    modport slave  (input  i_en_a, i_we_a, i_addr_a, i_din_a,
                           i_en_b, i_we_b, i_addr_b, i_din_b,
                    output o_dout_a, o_dout_b);
`endif
endinterface

// File: rtl/dpm_port_pipe.sv
// Per-port pipeline: delays encoded writes to their commit edge, captures read
// requests, and delays decoded read results to the port's output latency.
module dpm_port_pipe #(
    parameter int ADDR_WIDTH    = 5,
    parameter int CODE_WIDTH    = 12,
    parameter int RES_WIDTH     = 8,
    parameter int WRITE_LATENCY = 4,
    parameter int READ_LATENCY  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [CODE_WIDTH-1:0] i_code,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [CODE_WIDTH-1:0] o_wr_code,
    output logic                  o_rd_req,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic                  i_res_valid,
    input  logic [RES_WIDTH-1:0]  i_res,
    output logic [RES_WIDTH-1:0]  o_res
);
    localparam int RD_STAGES = READ_LATENCY - 1;

    if (WRITE_LATENCY < 1 || READ_LATENCY < 2) begin : g_bad_latency
        $error("dpm_port_pipe: WRITE_LATENCY must be >= 1 and READ_LATENCY >= 2");
    end

    logic [WRITE_LATENCY-1:0] r_wv;
    logic [ADDR_WIDTH-1:0]    r_wa [WRITE_LATENCY];
    logic [CODE_WIDTH-1:0]    r_wc [WRITE_LATENCY];
    logic                     r_rv;
    logic [ADDR_WIDTH-1:0]    r_ra;
    logic [RD_STAGES-1:0]     r_ov;
    logic [RD_STAGES-1:0]     w_sv;
    logic [RES_WIDTH-1:0]     r_od [RD_STAGES];
    logic [RES_WIDTH-1:0]     w_sd [RD_STAGES];

    // Write shift chain; the last stage drives the array commit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wv <= '0;
            for (int k = 0; k < WRITE_LATENCY; k++) begin
                r_wa[k] <= '0;
                r_wc[k] <= '0;
            end
        end else begin
            r_wv    <= (r_wv << 1'b1) | WRITE_LATENCY'(i_en & i_we);
            r_wa[0] <= i_addr;
            r_wc[0] <= i_code;
            for (int k = 1; k < WRITE_LATENCY; k++) begin
                r_wa[k] <= r_wa[k-1];
                r_wc[k] <= r_wc[k-1];
            end
        end
    end

    // Read request capture at acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rv <= 1'b0;
            r_ra <= '0;
        end else begin
            r_rv <= i_en & ~i_we;
            r_ra <= i_addr;
        end
    end

    // Inputs feeding each result-delay stage.
    always_comb begin
        w_sv    = (r_ov << 1'b1) | RD_STAGES'(i_res_valid);
        w_sd[0] = i_res;
        for (int k = 1; k < RD_STAGES; k++) w_sd[k] = r_od[k-1];
    end

    // Result delay; the final stage only changes when a read result reaches it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ov <= '0;
            for (int k = 0; k < RD_STAGES; k++) r_od[k] <= '0;
        end else begin
            r_ov <= w_sv;
            for (int k = 0; k < RD_STAGES; k++) begin
                if (w_sv[k]) r_od[k] <= w_sd[k];
            end
        end
    end

    assign o_wr_en   = r_wv[WRITE_LATENCY-1];
    assign o_wr_addr = r_wa[WRITE_LATENCY-1];
    assign o_wr_code = r_wc[WRITE_LATENCY-1];
    assign o_rd_req  = r_rv;
    assign o_rd_addr = r_ra;
    assign o_res     = r_od[RD_STAGES-1];

endmodule

// File: rtl/dual_port_ecc_mem.sv
// True dual-port banked memory with Hamming SEC on every word.
// Optional DPM_ECC_DEBUG_EN: codeword bit-0 flip injection and per-port correction flags.
module dual_port_ecc_mem
    import dpm_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int CODE_WIDTH      = 12,
    parameter int ADDR_WIDTH      = 5,
    parameter int DEPTH           = 2 ** ADDR_WIDTH,
    parameter int NUM_BANK        = 4,
    parameter int WRITE_LATENCY_A = 4,
    parameter int READ_LATENCY_A  = 5,
    parameter int WRITE_LATENCY_B = 4,
    parameter int READ_LATENCY_B  = 5
) (
    input logic         i_clk,
    input logic         i_rst,
    dual_port_vif.slave bus
);
    localparam int ROWS       = DEPTH / NUM_BANK;
    localparam int BANK_IDX_W = idx_bits(NUM_BANK);
    localparam int ROW_IDX_W  = idx_bits(ROWS);
`ifdef DPM_ECC_DEBUG_EN
    localparam int RES_W = WIDTH + 1;
`else
    localparam int RES_W = WIDTH;
`endif

    if (CODE_WIDTH != WIDTH + calc_parity_bits(WIDTH) || WIDTH > MAX_W || CODE_WIDTH > MAX_CW
        || NUM_BANK < 1 || (NUM_BANK & (NUM_BANK - 1)) != 0 || NUM_BANK > DEPTH)
    begin : g_bad_config
        $error("dual_port_ecc_mem: inconsistent CODE_WIDTH/WIDTH or NUM_BANK");
    end

    typedef logic [CODE_WIDTH-1:0] codeword_t;

    codeword_t             r_bank [NUM_BANK][ROWS];
    codeword_t             w_enc_a, w_enc_b, w_code_a, w_code_b;
    codeword_t             w_wr_code_a, w_wr_code_b, r_rcode_a, r_rcode_b;
    logic                  w_wr_en_a, w_wr_en_b, w_rd_req_a, w_rd_req_b, r_rv_a, r_rv_b;
    logic [ADDR_WIDTH-1:0] w_wr_addr_a, w_wr_addr_b, w_rd_addr_a, w_rd_addr_b;
    logic [RES_W-1:0]      w_res_a, w_res_b, w_out_a, w_out_b;

    function automatic logic [BANK_IDX_W-1:0] bank_of(input logic [ADDR_WIDTH-1:0] addr);
        return BANK_IDX_W'(int'(addr) % NUM_BANK);
    endfunction

    function automatic logic [ROW_IDX_W-1:0] row_of(input logic [ADDR_WIDTH-1:0] addr);
        return ROW_IDX_W'(int'(addr) / NUM_BANK);
    endfunction

    function automatic logic ecc_corrected(input codeword_t code);
        logic [SYN_W-1:0] syn;
        syn = hamming_syndrome(MAX_CW'(code), CODE_WIDTH);
        return (syn != '0) && (int'(syn) <= CODE_WIDTH);
    endfunction

    // Syndromes pointing past the codeword are uncorrectable; data passes through as stored.
    function automatic logic [WIDTH-1:0] ecc_correct(input codeword_t code);
        logic [SYN_W-1:0] syn;
        codeword_t        fixed;
        syn   = hamming_syndrome(MAX_CW'(code), CODE_WIDTH);
        fixed = code;
        for (int i = 0; i < CODE_WIDTH; i++) begin
            if (int'(syn) == i + 1) fixed[i] = ~fixed[i];
        end
        return WIDTH'(hamming_data(MAX_CW'(fixed), CODE_WIDTH));
    endfunction

    assign w_enc_a = CODE_WIDTH'(hamming_encode(MAX_W'(bus.i_din_a), WIDTH, CODE_WIDTH));
    assign w_enc_b = CODE_WIDTH'(hamming_encode(MAX_W'(bus.i_din_b), WIDTH, CODE_WIDTH));
`ifdef DPM_ECC_DEBUG_EN
    assign w_code_a      = w_enc_a ^ {{(CODE_WIDTH-1){1'b0}}, bus.i_flip_a};
    assign w_code_b      = w_enc_b ^ {{(CODE_WIDTH-1){1'b0}}, bus.i_flip_b};
    assign w_res_a       = {ecc_corrected(r_rcode_a), ecc_correct(r_rcode_a)};
    assign w_res_b       = {ecc_corrected(r_rcode_b), ecc_correct(r_rcode_b)};
    assign bus.o_corr_a  = w_out_a[WIDTH];
    assign bus.o_corr_b  = w_out_b[WIDTH];
`else
    assign w_code_a      = w_enc_a;
    assign w_code_b      = w_enc_b;
    assign w_res_a       = ecc_correct(r_rcode_a);
    assign w_res_b       = ecc_correct(r_rcode_b);
`endif
    assign bus.o_dout_a = w_out_a[WIDTH-1:0];
    assign bus.o_dout_b = w_out_b[WIDTH-1:0];

    dpm_port_pipe #(
        .ADDR_WIDTH(ADDR_WIDTH), .CODE_WIDTH(CODE_WIDTH), .RES_WIDTH(RES_W),
        .WRITE_LATENCY(WRITE_LATENCY_A), .READ_LATENCY(READ_LATENCY_A)
    ) u_pipe_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(bus.i_en_a), .i_we(bus.i_we_a),
        .i_addr(bus.i_addr_a), .i_code(w_code_a),
        .o_wr_en(w_wr_en_a), .o_wr_addr(w_wr_addr_a), .o_wr_code(w_wr_code_a),
        .o_rd_req(w_rd_req_a), .o_rd_addr(w_rd_addr_a),
        .i_res_valid(r_rv_a), .i_res(w_res_a), .o_res(w_out_a)
    );

    dpm_port_pipe #(
        .ADDR_WIDTH(ADDR_WIDTH), .CODE_WIDTH(CODE_WIDTH), .RES_WIDTH(RES_W),
        .WRITE_LATENCY(WRITE_LATENCY_B), .READ_LATENCY(READ_LATENCY_B)
    ) u_pipe_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(bus.i_en_b), .i_we(bus.i_we_b),
        .i_addr(bus.i_addr_b), .i_code(w_code_b),
        .o_wr_en(w_wr_en_b), .o_wr_addr(w_wr_addr_b), .o_wr_code(w_wr_code_b),
        .o_rd_req(w_rd_req_b), .o_rd_addr(w_rd_addr_b),
        .i_res_valid(r_rv_b), .i_res(w_res_b), .o_res(w_out_b)
    );

    // Array commits; on a same-address collision port B is dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_wr_en_b && !(w_wr_en_a && w_wr_addr_a == w_wr_addr_b)) begin
                r_bank[bank_of(w_wr_addr_b)][row_of(w_wr_addr_b)] <= w_wr_code_b;
            end
            if (w_wr_en_a) begin
                r_bank[bank_of(w_wr_addr_a)][row_of(w_wr_addr_a)] <= w_wr_code_a;
            end
        end
    end

    // Array read one edge after acceptance; sees contents from before same-edge commits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rv_a    <= 1'b0;
            r_rv_b    <= 1'b0;
            r_rcode_a <= '0;
            r_rcode_b <= '0;
        end else begin
            r_rv_a    <= w_rd_req_a;
            r_rv_b    <= w_rd_req_b;
            r_rcode_a <= r_bank[bank_of(w_rd_addr_a)][row_of(w_rd_addr_a)];
            r_rcode_b <= r_bank[bank_of(w_rd_addr_b)][row_of(w_rd_addr_b)];
        end
    end

endmodule

// File: tb/tb_dual_port_ecc_mem.sv
// Randomised and directed bench for dual_port_ecc_mem against a transaction-level
// model (address-indexed store plus timed write/read queues). Optional DPM_ECC_DEBUG_EN.
module tb_dual_port_ecc_mem;

    localparam int AW    = 5;
    localparam int W     = 8;
    localparam int WL    = 4;
    localparam int RL    = 5;
    localparam int DEPTH = 32;

    typedef struct {int at; int port; int addr; int data; bit flip;} wr_t;
    typedef struct {int cap; int outp; int port; int addr; int data; bit corr;} rd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dual_port_vif #(.ADDR_WIDTH(AW), .WIDTH(W)) bus ();

    dual_port_ecc_mem #(
        .WIDTH(W), .CODE_WIDTH(12), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_BANK(4),
        .WRITE_LATENCY_A(WL), .READ_LATENCY_A(RL), .WRITE_LATENCY_B(WL), .READ_LATENCY_B(RL)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );

    int  n_checks, n_pass, edge_n;
    bit  sh_en [2], sh_we [2], sh_fl [2];
    int  sh_addr [2], sh_din [2];
    int  mem [DEPTH];
    bit  mflip [DEPTH];
    int  exp_d [2];
    bit  exp_c [2];
    wr_t wq [$];
    rd_t rq [$];

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, act, exp, edge_n);
    endtask

    function automatic int fill_val(input int a);
        return (a * 37 + 11) & 255;
    endfunction

    task automatic set_port(input int p, input bit en, input bit we, input int addr,
                            input int data, input bit flip);
        sh_en[p] = en; sh_we[p] = we; sh_addr[p] = addr; sh_din[p] = data; sh_fl[p] = flip;
        if (p == 0) begin
            bus.i_en_a = en; bus.i_we_a = we; bus.i_addr_a = AW'(addr); bus.i_din_a = W'(data);
`ifdef DPM_ECC_DEBUG_EN
            bus.i_flip_a = flip;
`endif
        end else begin
            bus.i_en_b = en; bus.i_we_b = we; bus.i_addr_b = AW'(addr); bus.i_din_b = W'(data);
`ifdef DPM_ECC_DEBUG_EN
            bus.i_flip_b = flip;
`endif
        end
    endtask

    // Reference behaviour at one rising edge: capture reads, deliver results, commit, accept.
    task automatic model_edge();
        int e;
        e = edge_n;
        if (rst) begin
            wq.delete(); rq.delete();
            exp_d[0] = 0; exp_d[1] = 0; exp_c[0] = 1'b0; exp_c[1] = 1'b0;
            return;
        end
        foreach (rq[i]) if (rq[i].cap == e) begin
            rq[i].data = mem[rq[i].addr];
            rq[i].corr = mflip[rq[i].addr];
        end
        for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].outp == e) begin
            exp_d[rq[i].port] = rq[i].data;
            exp_c[rq[i].port] = rq[i].corr;
            rq.delete(i);
        end
        for (int p = 1; p >= 0; p--) foreach (wq[i]) if (wq[i].at == e && wq[i].port == p) begin
            mem[wq[i].addr]   = wq[i].data;
            mflip[wq[i].addr] = wq[i].flip;
        end
        for (int i = wq.size() - 1; i >= 0; i--) if (wq[i].at == e) wq.delete(i);
        for (int p = 0; p < 2; p++) if (sh_en[p]) begin
            if (sh_we[p]) wq.push_back('{e + WL, p, sh_addr[p], sh_din[p], sh_fl[p]});
            else          rq.push_back('{e + 1, e + RL, p, sh_addr[p], 0, 1'b0});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        edge_n++;
        #1;
        check_val("dout_a", int'(bus.o_dout_a), exp_d[0]);
        check_val("dout_b", int'(bus.o_dout_b), exp_d[1]);
`ifdef DPM_ECC_DEBUG_EN
        check_val("corr_a", int'(bus.o_corr_a), int'(exp_c[0]));
        check_val("corr_b", int'(bus.o_corr_b), int'(exp_c[1]));
`endif
    endtask

    task automatic idle(input int n);
        set_port(0, 1'b0, 1'b0, 0, 0, 1'b0);
        set_port(1, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (n) cycle();
    endtask

    initial begin
        n_checks = 0; n_pass = 0; edge_n = 0;
        exp_d[0] = 0; exp_d[1] = 0; exp_c[0] = 1'b0; exp_c[1] = 1'b0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            set_port(0, 1'b1, 1'b1, i, fill_val(i), 1'b0);
            set_port(1, 1'b1, 1'b1, i + 16, fill_val(i + 16), 1'b0);
            cycle();
        end
        idle(WL + 1);

        // Write-then-read latency on port A.
        set_port(0, 1'b1, 1'b1, 5, 32'hA5, 1'b0); cycle(); idle(3);
        set_port(0, 1'b1, 1'b0, 5, 0, 1'b0); cycle(); idle(5);
        check_val("t1_rd_a5", int'(bus.o_dout_a), 32'hA5);

        // Read-first: B's read in the same cycle as A's write sees the old word.
        set_port(0, 1'b1, 1'b1, 5, 32'h3C, 1'b0); set_port(1, 1'b1, 1'b0, 5, 0, 1'b0);
        cycle(); idle(3);
        set_port(0, 1'b1, 1'b0, 5, 0, 1'b0); cycle(); idle(1);
        check_val("t2_b_old", int'(bus.o_dout_b), 32'hA5);
        idle(4);
        check_val("t2_a_new", int'(bus.o_dout_a), 32'h3C);

        // Collision on addr 7, then concurrent commits into the same bank.
        set_port(0, 1'b1, 1'b1, 7, 32'h11, 1'b0); set_port(1, 1'b1, 1'b1, 7, 32'h22, 1'b0); cycle();
        set_port(0, 1'b1, 1'b1, 0, 32'h01, 1'b0); set_port(1, 1'b1, 1'b1, 4, 32'h04, 1'b0); cycle();
        idle(4);
        set_port(0, 1'b1, 1'b0, 7, 0, 1'b0); set_port(1, 1'b1, 1'b0, 0, 0, 1'b0); cycle();
        set_port(0, 1'b1, 1'b0, 4, 0, 1'b0); set_port(1, 1'b0, 1'b0, 0, 0, 1'b0); cycle();
        idle(4);
        check_val("t3_coll_a", int'(bus.o_dout_a), 32'h11);
        check_val("t3_bank_0", int'(bus.o_dout_b), 32'h01);
        idle(1);
        check_val("t3_bank_4", int'(bus.o_dout_a), 32'h04);

`ifdef DPM_ECC_DEBUG_EN
        set_port(0, 1'b1, 1'b1, 9, 32'hFF, 1'b1); cycle(); idle(4);
        set_port(0, 1'b1, 1'b0, 9, 0, 1'b0); cycle(); idle(5);
        check_val("t4_flip_data", int'(bus.o_dout_a), 32'hFF);
        check_val("t4_flip_corr", int'(bus.o_corr_a), 32'h1);
        set_port(0, 1'b1, 1'b0, 10, 0, 1'b0); cycle(); idle(5);
        check_val("t4_clean_corr", int'(bus.o_corr_a), 32'h0);
`endif

        // Reset discards an in-flight write and clears both outputs.
        set_port(0, 1'b1, 1'b1, 3, 32'h77, 1'b0); cycle(); idle(1);
        rst = 1'b1; idle(1);
        check_val("t5_rst_a", int'(bus.o_dout_a), 32'h0);
        check_val("t5_rst_b", int'(bus.o_dout_b), 32'h0);
        rst = 1'b0; idle(3);
        set_port(0, 1'b1, 1'b0, 3, 0, 1'b0); cycle(); idle(5);
        check_val("t5_keep_3", int'(bus.o_dout_a), fill_val(3));

        // Back-to-back streaming reads over the whole address range.
        for (int i = 0; i < DEPTH; i++) begin
            set_port(0, 1'b1, 1'b0, i, 0, 1'b0);
            set_port(1, 1'b1, 1'b0, DEPTH - 1 - i, 0, 1'b0);
            cycle();
        end
        idle(RL);

        // Random traffic with forced address collisions and occasional resets.
        repeat (400) begin
            int a_addr;
            bit fa, fb;
            a_addr = $urandom_range(0, DEPTH - 1);
            fa = 1'b0; fb = 1'b0;
`ifdef DPM_ECC_DEBUG_EN
            fa = ($urandom_range(0, 7) == 0); fb = ($urandom_range(0, 7) == 0);
`endif
            set_port(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a_addr,
                     $urandom_range(0, 255), fa);
            set_port(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     ($urandom_range(0, 3) == 0) ? a_addr : $urandom_range(0, DEPTH - 1),
                     $urandom_range(0, 255), fb);
            rst = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(RL + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
